// File: rtl/mips_pkg.sv
// Shared MIPS memory-stage constants: read-mux selects and user-port addresses.
package mips_pkg;

   localparam int unsigned DATA_WIDTH_DEFAULT = 32;
   localparam int unsigned MUX_SEL_WIDTH      = 2;

   // Read-mux selects produced by the memory-mapped I/O decoder
   localparam logic [MUX_SEL_WIDTH-1:0] MUX_SEL_RAM   = 2'b00;
   localparam logic [MUX_SEL_WIDTH-1:0] MUX_SEL_PORT0 = 2'b01;
   localparam logic [MUX_SEL_WIDTH-1:0] MUX_SEL_PORT1 = 2'b10;
   localparam logic [MUX_SEL_WIDTH-1:0] MUX_SEL_RSVD  = 2'b11;

   // User-port byte addresses, shared with the decoder
   localparam logic [31:0] ADDR_OUT_PORT = 32'h0000_FFF0;
   localparam logic [31:0] ADDR_IN_PORT0 = 32'h0000_FFF4;
   localparam logic [31:0] ADDR_IN_PORT1 = 32'h0000_FFF8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous input bus; q is the last stage.
module sync_chain #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];

   // Shift the pin value through the chain; reset clears every stage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/io_port_unit.sv
// User I/O port unit: output port register, synchronized input ports with
// sticky change flags, and the RAM-latency-aligned load read mux.
module io_port_unit
   import mips_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     out_en,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic [MUX_SEL_WIDTH-1:0] mux_sel,
   input  logic [DATA_WIDTH-1:0]    ram_rd_data,
   input  logic [DATA_WIDTH-1:0]    in_port0,
   input  logic [DATA_WIDTH-1:0]    in_port1,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic [DATA_WIDTH-1:0]    out_port,
   output logic                     out_strobe,
   output logic                     in0_changed,
   output logic                     in1_changed
);

   logic [DATA_WIDTH-1:0]    sync0;
   logic [DATA_WIDTH-1:0]    sync1;
   logic [DATA_WIDTH-1:0]    prev0;
   logic [DATA_WIDTH-1:0]    prev1;
   logic [MUX_SEL_WIDTH-1:0] sel_q;

   sync_chain #(
      .WIDTH  (DATA_WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync0 (
      .clk (clk),
      .rst (rst),
      .d   (in_port0),
      .q   (sync0)
   );

   sync_chain #(
      .WIDTH  (DATA_WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync1 (
      .clk (clk),
      .rst (rst),
      .d   (in_port1),
      .q   (sync1)
   );

   // Output port register; strobe pulses on every cycle that loads it
   always_ff @(posedge clk) begin
      if (rst) begin
         out_port   <= '0;
         out_strobe <= 1'b0;
      end else if (out_en) begin
         out_port   <= wr_data;
         out_strobe <= 1'b1;
      end else begin
         out_strobe <= 1'b0;
      end
   end

   // Previous synchronized values, used to detect a change
   always_ff @(posedge clk) begin
      if (rst) begin
         prev0 <= '0;
         prev1 <= '0;
      end else begin
         prev0 <= sync0;
         prev1 <= sync1;
      end
   end

   // Read select delayed one cycle to line up with the RAM read latency
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q <= MUX_SEL_RAM;
      end else begin
         sel_q <= mux_sel;
      end
   end

   // Sticky change flag for port 0; a new change beats a completing read
   always_ff @(posedge clk) begin
      if (rst) begin
         in0_changed <= 1'b0;
      end else if (sync0 != prev0) begin
         in0_changed <= 1'b1;
      end else if (sel_q == MUX_SEL_PORT0) begin
         in0_changed <= 1'b0;
      end
   end

   // Sticky change flag for port 1; a new change beats a completing read
   always_ff @(posedge clk) begin
      if (rst) begin
         in1_changed <= 1'b0;
      end else if (sync1 != prev1) begin
         in1_changed <= 1'b1;
      end else if (sel_q == MUX_SEL_PORT1) begin
         in1_changed <= 1'b0;
      end
   end

   // Load result to writeback; reserved select reads as zero
   always_comb begin
      rd_data = '0;
      case (sel_q)
         MUX_SEL_RAM:   rd_data = ram_rd_data;
         MUX_SEL_PORT0: rd_data = sync0;
         MUX_SEL_PORT1: rd_data = sync1;
         default:       rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_io_port_unit.sv
// Bench for io_port_unit: directed vector table, back-to-back store sequence,
// then randomized traffic checked against a history-based reference model.
module tb_io_port_unit;

   localparam int unsigned DW   = 32;
   localparam int unsigned SYNC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          out_en;
   logic [DW-1:0] wr_data;
   logic [1:0]    mux_sel;
   logic [DW-1:0] ram_rd_data;
   logic [DW-1:0] in_port0;
   logic [DW-1:0] in_port1;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] out_port;
   logic          out_strobe;
   logic          in0_changed;
   logic          in1_changed;

   int n_cmp  = 0;
   int n_fail = 0;

   io_port_unit #(
      .DATA_WIDTH  (DW),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .out_en      (out_en),
      .wr_data     (wr_data),
      .mux_sel     (mux_sel),
      .ram_rd_data (ram_rd_data),
      .in_port0    (in_port0),
      .in_port1    (in_port1),
      .rd_data     (rd_data),
      .out_port    (out_port),
      .out_strobe  (out_strobe),
      .in0_changed (in0_changed),
      .in1_changed (in1_changed)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          out_en;
      logic [DW-1:0] wr_data;
      logic [1:0]    sel;
      logic [DW-1:0] ram;
      logic [DW-1:0] in0;
      logic [DW-1:0] in1;
      logic [DW-1:0] e_out;
      logic          e_stb;
      logic          e_f0;
      logic          e_f1;
      logic [DW-1:0] e_rd;
   } vec_t;

   vec_t vecs[$];

   // Reference model: pin values seen at each edge since the last reset
   logic [DW-1:0] hist0[$];
   logic [DW-1:0] hist1[$];
   logic          m_f0, m_f1, m_stb;
   logic [DW-1:0] m_out;
   logic [1:0]    m_sel;

   function automatic logic [DW-1:0] msync0(int back);
      int idx = hist0.size() - int'(SYNC) - back;
      return (idx < 0) ? '0 : hist0[idx];
   endfunction

   function automatic logic [DW-1:0] msync1(int back);
      int idx = hist1.size() - int'(SYNC) - back;
      return (idx < 0) ? '0 : hist1[idx];
   endfunction

   function automatic logic [DW-1:0] m_rd();
      case (m_sel)
         2'b00:   return ram_rd_data;
         2'b01:   return msync0(0);
         2'b10:   return msync1(0);
         default: return '0;
      endcase
   endfunction

   task automatic model_edge();
      logic nf0, nf1;
      if (rst) begin
         hist0.delete();
         hist1.delete();
         m_f0 = 1'b0; m_f1 = 1'b0; m_stb = 1'b0; m_out = '0; m_sel = 2'b00;
      end else begin
         nf0 = (msync0(0) != msync0(1)) ? 1'b1 : ((m_sel == 2'b01) ? 1'b0 : m_f0);
         nf1 = (msync1(0) != msync1(1)) ? 1'b1 : ((m_sel == 2'b10) ? 1'b0 : m_f1);
         m_f0 = nf0;
         m_f1 = nf1;
         hist0.push_back(in_port0);
         hist1.push_back(in_port1);
         if (out_en) m_out = wr_data;
         m_stb = out_en;
         m_sel = mux_sel;
      end
   endtask

   task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic r, logic oe, logic [DW-1:0] wd, logic [1:0] s,
                        logic [DW-1:0] rm, logic [DW-1:0] i0, logic [DW-1:0] i1);
      rst = r; out_en = oe; wr_data = wd; mux_sel = s;
      ram_rd_data = rm; in_port0 = i0; in_port1 = i1;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic add(logic r, logic oe, logic [DW-1:0] wd, logic [1:0] s,
                      logic [DW-1:0] rm, logic [DW-1:0] i0, logic [DW-1:0] i1,
                      logic [DW-1:0] eo, logic es, logic e0, logic e1, logic [DW-1:0] er);
      vec_t v;
      v.rst = r; v.out_en = oe; v.wr_data = wd; v.sel = s; v.ram = rm;
      v.in0 = i0; v.in1 = i1; v.e_out = eo; v.e_stb = es; v.e_f0 = e0;
      v.e_f1 = e1; v.e_rd = er;
      vecs.push_back(v);
   endtask

   initial begin
      rst = 1'b1; out_en = 1'b0; wr_data = '0; mux_sel = 2'b00;
      ram_rd_data = '0; in_port0 = '0; in_port1 = '0;
      m_f0 = 1'b0; m_f1 = 1'b0; m_stb = 1'b0; m_out = '0; m_sel = 2'b00;

      //   rst oe wr_data       sel    ram           in0           in1           out          stb f0 f1 rd
      add(1, 1, 32'h0,        2'b00, 32'hAAAA,     32'hDEAD_BEEF, 32'h0,       32'h0,       0, 0, 0, 32'hAAAA);
      add(1, 1, 32'h0,        2'b00, 32'hAAAA,     32'hDEAD_BEEF, 32'h0,       32'h0,       0, 0, 0, 32'hAAAA);
      add(0, 1, 32'hA5,       2'b00, 32'h0,        32'h0,        32'h55,      32'hA5,      1, 0, 0, 32'h0);
      add(0, 0, 32'h0,        2'b00, 32'h0,        32'h0,        32'h55,      32'hA5,      0, 0, 0, 32'h0);
      add(0, 0, 32'h0,        2'b00, 32'h0,        32'h3,        32'h55,      32'hA5,      0, 0, 1, 32'h0);
      add(0, 0, 32'h0,        2'b00, 32'h0,        32'h3,        32'h55,      32'hA5,      0, 0, 1, 32'h0);
      add(0, 0, 32'h0,        2'b00, 32'h0,        32'h3,        32'h55,      32'hA5,      0, 1, 1, 32'h0);
      add(0, 0, 32'h0,        2'b01, 32'h0,        32'h3,        32'h55,      32'hA5,      0, 1, 1, 32'h3);
      add(0, 0, 32'h0,        2'b00, 32'h1234_5678, 32'h3,       32'h55,      32'hA5,      0, 0, 1, 32'h1234_5678);
      add(0, 0, 32'h0,        2'b10, 32'h1234_5678, 32'h3,       32'h55,      32'hA5,      0, 0, 1, 32'h55);
      add(0, 0, 32'h0,        2'b11, 32'h1234_5678, 32'h3,       32'h55,      32'hA5,      0, 0, 0, 32'h0);
      add(0, 0, 32'h0,        2'b00, 32'h1234_5678, 32'h3,       32'h77,      32'hA5,      0, 0, 0, 32'h1234_5678);
      add(0, 0, 32'h0,        2'b10, 32'h1234_5678, 32'h3,       32'h77,      32'hA5,      0, 0, 0, 32'h77);
      add(0, 0, 32'h0,        2'b00, 32'h1234_5678, 32'h3,       32'h77,      32'hA5,      0, 0, 1, 32'h1234_5678);
      add(1, 1, 32'hFFFF_FFFF, 2'b00, 32'h1234_5678, 32'h3,      32'h77,      32'h0,       0, 0, 0, 32'h1234_5678);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].out_en, vecs[i].wr_data, vecs[i].sel,
               vecs[i].ram, vecs[i].in0, vecs[i].in1);
         check($sformatf("vec%0d out_port", i), out_port, vecs[i].e_out);
         check($sformatf("vec%0d out_strobe", i), DW'(out_strobe), DW'(vecs[i].e_stb));
         check($sformatf("vec%0d in0_changed", i), DW'(in0_changed), DW'(vecs[i].e_f0));
         check($sformatf("vec%0d in1_changed", i), DW'(in1_changed), DW'(vecs[i].e_f1));
         check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].e_rd);
      end

      // Back-to-back stores: strobe stays high, last write wins, then drops
      drive(0, 1, 32'h1, 2'b00, 32'h0, 32'h0, 32'h0);
      check("b2b1 out_port", out_port, 32'h1);
      check("b2b1 out_strobe", DW'(out_strobe), 32'h1);
      drive(0, 1, 32'h2, 2'b00, 32'h0, 32'h0, 32'h0);
      check("b2b2 out_strobe", DW'(out_strobe), 32'h1);
      drive(0, 1, 32'h3, 2'b00, 32'h0, 32'h0, 32'h0);
      check("b2b3 out_port", out_port, 32'h3);
      drive(0, 0, 32'h9, 2'b00, 32'h0, 32'h0, 32'h0);
      check("b2b idle out_port", out_port, 32'h3);
      check("b2b idle out_strobe", DW'(out_strobe), 32'h0);

      // Randomized traffic against the reference model, starting from reset
      drive(1, 0, 32'h0, 2'b00, 32'h0, 32'h0, 32'h0);
      for (int c = 0; c < 3000; c++) begin
         logic          r;
         logic [DW-1:0] i0, i1;
         r  = ($urandom_range(0, 99) == 0);
         i0 = ($urandom_range(0, 5) == 0) ? DW'($urandom_range(0, 7)) : in_port0;
         i1 = ($urandom_range(0, 5) == 0) ? DW'($urandom()) : in_port1;
         drive(r, 1'($urandom()), DW'($urandom()), 2'($urandom()),
               DW'($urandom()), i0, i1);
         check("rnd out_port", out_port, m_out);
         check("rnd out_strobe", DW'(out_strobe), DW'(m_stb));
         check("rnd in0_changed", DW'(in0_changed), DW'(m_f0));
         check("rnd in1_changed", DW'(in1_changed), DW'(m_f1));
         check("rnd rd_data", rd_data, m_rd());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
- Downstream data-path partner of the memory-mapped I/O decoder in the MIPS memory stage.
- Consumes the decoder's out_en and mux_sel and holds the user output port register.
- Synchronizes the two asynchronous user input ports and records change flags for them.
- Registers the read-select so it lines up with the one-cycle-latency data RAM, then drives the word returned to the writeback mux.

Parameters:
- DATA_WIDTH, 32, width of the data bus and of every port.
- SYNC_STAGES, 2, number of flip-flop stages in each input synchronizer (legal values 2..4).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- out_en  input  1  from the decoder; a store to the user output port is in progress this cycle.
- wr_data  input  DATA_WIDTH  store data (rt register value) for this cycle.
- mux_sel  input  2  from the decoder: 00 = RAM, 01 = user port 0, 10 = user port 1, 11 = reserved.
- ram_rd_data  input  DATA_WIDTH  data RAM read word; valid one cycle after its address.
- in_port0  input  DATA_WIDTH  asynchronous user input port 0 (switches).
- in_port1  input  DATA_WIDTH  asynchronous user input port 1.
- rd_data  output  DATA_WIDTH  load result delivered to the writeback mux.
- out_port  output  DATA_WIDTH  registered user output port (LEDs / 7-segment display).
- out_strobe  output  1  one-cycle pulse when out_port takes a new value.
- in0_changed  output  1  sticky flag: synchronized port 0 has changed since it was last read.
- in1_changed  output  1  sticky flag: same, for port 1.

Behaviour:
- Reset (rst high at a clk edge) clears all of the following to 0: out_port, out_strobe, every synchronizer stage, the previous-value registers, sel_q, in0_changed, in1_changed.
  - rd_data then reads ram_rd_data because sel_q = 00.
  - Reset takes priority over every other event in the same cycle, including out_en.
- Output port:
  - If out_en = 1 at an edge, out_port <= wr_data and out_strobe <= 1 on that edge.
  - Otherwise out_port holds and out_strobe <= 0.
  - Back-to-back out_en cycles: each cycle loads, out_strobe stays high, and the last write wins.
- Input synchronizers:
  - in_portN passes through a SYNC_STAGES-deep flop chain; the last stage is syncN.
  - Latency from a pin change to syncN is SYNC_STAGES cycles.
  - prevN <= syncN every cycle.
- Change flags:
  - Set condition: syncN != prevN at an edge.
  - Clear condition: sel_q selects port N at an edge (the read has been consumed).
  - If set and clear occur in the same cycle, set wins.
- Read path:
  - sel_q <= mux_sel every cycle, so sel_q aligns with the RAM latency.
  - rd_data is combinational from sel_q:
    - 00 -> ram_rd_data
    - 01 -> sync0
    - 10 -> sync1
    - 11 -> all zeros
  - Load-use timing: rd_data is valid in the cycle after the load's address cycle, for both RAM and port loads.
  - A store in cycle N followed by a port-0 load in cycle N+1 is independent of the store; rd_data in cycle N+2 shows sync0.
- No handshake back-pressure; the block is always ready.
- DATA_WIDTH bits are passed unchanged; no sign or zero extension (the byte/half path is handled elsewhere).

Decomposition:
- Shared package (mips_pkg) holds:
  - MUX_SEL_RAM = 2'b00, MUX_SEL_PORT0 = 2'b01, MUX_SEL_PORT1 = 2'b10.
  - The user-port address constants, shared with the decoder.
  - DATA_WIDTH default 32.
- One sub-module: sync_chain (parameters WIDTH and STAGES; ports clk, rst, d, q).
  - Instantiated twice.
  - Contains the synchronous reset of its stages.

Test Plan:
- Reset: drive in_port0 = 32'hDEAD_BEEF and out_en = 1, assert rst for 2 cycles -> out_port = 0, out_strobe = 0, both flags 0, rd_data equals ram_rd_data.
- Output write: out_en = 1 with wr_data = 32'h0000_00A5 for 1 cycle -> next cycle out_port = 32'hA5 and out_strobe = 1; following cycle out_strobe = 0 and out_port holds.
- Sync latency and flag:
  - Step in_port0 from 0 to 32'h0000_0003 -> sync0 updates after exactly 2 cycles and in0_changed sets the cycle after.
  - Then mux_sel = 01 for 1 cycle -> one cycle later rd_data = 3, and in0_changed clears on the following edge.
- RAM alignment:
  - Set mux_sel = 00 with ram_rd_data = 32'h1234_5678 presented one cycle later -> rd_data = 32'h1234_5678.
  - Then mux_sel = 10 with in_port1 stable at 32'h55 -> next cycle rd_data = 32'h55.
- Simultaneous set and clear: change in_port1 so that its set edge coincides with sel_q = 10 -> in1_changed stays 1. Reserved select: mux_sel = 11 -> rd_data = 0.
- Reset mid-write: rst and out_en high in the same cycle with wr_data = 32'hFFFF_FFFF -> out_port = 0 and no strobe.
